// File: rtl/ca_project_pkg.sv
// rtl/ca_project_pkg.sv - shared opcodes, funct fields, ALU-op enum and ROM depth
package ca_project_pkg;

    localparam int ROM_DEPTH = 64;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_ZERO
    } alu_op_e;

endpackage

// File: rtl/ca_project_alu.sv
// rtl/ca_project_alu.sv - combinational 32-bit ALU
// Ports: op_a, op_b (operands), alu_op (operation), result (32-bit result).
module ca_project_alu
    import ca_project_pkg::*;
(
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  alu_op_e     alu_op,
    output logic [31:0] result
);

    always_comb begin
        result = 32'd0;
        case (alu_op)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_AND:  result = op_a & op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_XOR:  result = op_a ^ op_b;
            ALU_SLT:  result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLL:  result = op_a << op_b[4:0];
            ALU_SRL:  result = op_a >> op_b[4:0];
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/ca_project_top.sv
// rtl/ca_project_top.sv - single-cycle RV32I-subset processor with fixed ROM
// Ports: clk (clock), reset (sync active-high), Out_value (registered ALU result).
module ca_project_top
    import ca_project_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Out_value
);

    logic [7:0]  pc_q, pc_d;
    logic [31:0] out_value_q, out_value_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [31:0] instr;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val, imm, op_b, alu_result;
    alu_op_e     alu_op;
    logic        is_rtype, reg_we;

    // PC bits [1:0] are always zero; only the word index addresses the ROM.
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc_q[1:0];

    function automatic logic [31:0] rom_word(input logic [5:0] idx);
        case (idx)
            6'd0:    rom_word = 32'h0050_0093;  // ADDI x1,x0,5
            6'd1:    rom_word = 32'h0030_0113;  // ADDI x2,x0,3
            6'd2:    rom_word = 32'h0020_81B3;  // ADD  x3,x1,x2
            6'd3:    rom_word = 32'h4020_8233;  // SUB  x4,x1,x2
            6'd4:    rom_word = 32'h0020_F2B3;  // AND  x5,x1,x2
            6'd5:    rom_word = 32'h0020_E333;  // OR   x6,x1,x2
            6'd6:    rom_word = 32'h0020_C3B3;  // XOR  x7,x1,x2
            6'd7:    rom_word = 32'h0011_2433;  // SLT  x8,x2,x1
            6'd8:    rom_word = 32'h0020_94B3;  // SLL  x9,x1,x2
            6'd9:    rom_word = 32'h0024_D533;  // SRL  x10,x9,x2
            default: rom_word = 32'h0000_0013;  // NOP
        endcase
    endfunction

    assign instr   = rom_word(pc_q[7:2]);
    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign funct7  = instr[31:25];
    assign imm     = {{20{instr[31]}}, instr[31:20]};

    // Reads see the pre-edge register contents, so same-cycle writes are not forwarded.
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

    always_comb begin
        alu_op   = ALU_ZERO;
        reg_we   = 1'b0;
        is_rtype = 1'b0;
        if (opcode == OPC_RTYPE) begin
            is_rtype = 1'b1;
            reg_we   = 1'b1;
            if (funct7 == F7_BASE) begin
                case (funct3)
                    F3_ADD_SUB: alu_op = ALU_ADD;
                    F3_SLL:     alu_op = ALU_SLL;
                    F3_SLT:     alu_op = ALU_SLT;
                    F3_XOR:     alu_op = ALU_XOR;
                    F3_SRL:     alu_op = ALU_SRL;
                    F3_OR:      alu_op = ALU_OR;
                    F3_AND:     alu_op = ALU_AND;
                    default:    reg_we = 1'b0;
                endcase
            end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                alu_op = ALU_SUB;
            end else begin
                reg_we = 1'b0;
            end
        end else if (opcode == OPC_ITYPE && funct3 == F3_ADD_SUB) begin
            alu_op = ALU_ADD;
            reg_we = 1'b1;
        end
    end

    assign op_b = is_rtype ? rs2_val : imm;

    ca_project_alu u_alu (
        .op_a   (rs1_val),
        .op_b   (op_b),
        .alu_op (alu_op),
        .result (alu_result)
    );

    always_comb begin
        pc_d        = pc_q + 8'd4;
        out_value_d = alu_result;
        regs_d      = regs_q;
        if (reg_we && rd != 5'd0) begin
            regs_d[rd] = alu_result;
        end
        if (reset) begin
            pc_d        = 8'd0;
            out_value_d = 32'd0;
            for (int i = 0; i < 32; i++) begin
                regs_d[i] = 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_q        <= pc_d;
        out_value_q <= out_value_d;
        regs_q      <= regs_d;
    end

    assign Out_value = out_value_q;

endmodule

// File: tb/tb_ca_project_top.sv
// tb/tb_ca_project_top.sv - self-checking bench for ca_project_top
module tb_ca_project_top;

    logic        clk;
    logic        reset;
    logic [31:0] Out_value;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] out;
        int          rd;
        logic [31:0] val;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] final_regs [11];

    ca_project_top dut (
        .clk       (clk),
        .reset     (reset),
        .Out_value (Out_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs_cleared(input string name);
        for (int r = 0; r < 11; r++) begin
            check(name, dut.regs_q[r], 32'd0);
        end
    endtask

    task automatic check_regs_final(input string name);
        for (int r = 0; r < 11; r++) begin
            check(name, dut.regs_q[r], final_regs[r]);
        end
    endtask

    initial begin
        vecs[0] = '{32'd5,    1,  32'd5};
        vecs[1] = '{32'd3,    2,  32'd3};
        vecs[2] = '{32'd8,    3,  32'd8};
        vecs[3] = '{32'd2,    4,  32'd2};
        vecs[4] = '{32'd1,    5,  32'd1};
        vecs[5] = '{32'd7,    6,  32'd7};
        vecs[6] = '{32'd6,    7,  32'd6};
        vecs[7] = '{32'd1,    8,  32'd1};
        vecs[8] = '{32'h28,   9,  32'h28};
        vecs[9] = '{32'd5,    10, 32'd5};
        final_regs = '{32'd0, 32'd5, 32'd3, 32'd8, 32'd2, 32'd1,
                       32'd7, 32'd6, 32'd1, 32'h28, 32'd5};

        // Reset held for two edges.
        reset = 1'b1;
        for (int e = 0; e < 2; e++) begin
            step();
            check("reset_out", Out_value, 32'd0);
            check("reset_pc", {24'd0, dut.pc_q}, 32'd0);
        end
        check_regs_cleared("reset_regs");

        // Main program: edges 1..10.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("prog_out_%0d", i), Out_value, vecs[i].out);
            check($sformatf("prog_reg_x%0d", vecs[i].rd), dut.regs_q[vecs[i].rd], vecs[i].val);
        end

        // NOP region: edges 11..64.
        for (int e = 11; e <= 64; e++) begin
            step();
            check($sformatf("nop_out_%0d", e), Out_value, 32'd0);
        end
        check_regs_final("nop_regs");
        check("wrap_pc", {24'd0, dut.pc_q}, 32'd0);

        // Edge 65 re-executes word 0.
        step();
        check("wrap_out", Out_value, 32'd5);
        check_regs_final("wrap_regs");

        // Mid-program reset after edge 5 of a fresh run.
        reset = 1'b1;
        step();
        check("rst2_out", Out_value, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("rerun_out_%0d", i), Out_value, vecs[i].out);
        end
        reset = 1'b1;
        step();
        check("mid_rst_out", Out_value, 32'd0);
        check("mid_rst_pc", {24'd0, dut.pc_q}, 32'd0);
        check_regs_cleared("mid_rst_regs");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("restart_out_%0d", i), Out_value, vecs[i].out);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
